// File: rtl/div_meter_pkg.sv
// Shared FSM encoding and reference constants for the odd-ratio divider meter.
package div_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        MEAS  = 2'd2
    } meter_state_t;

    localparam int HC_PER_CYC = 2;

    localparam int EXP_PERIOD_DIV5 = 10;
    localparam int EXP_HIGH_DIV5   = 5;
    localparam int EXP_PERIOD_DIV7 = 14;
    localparam int EXP_HIGH_DIV7   = 7;
    localparam int EXP_PERIOD_DIV9 = 18;
    localparam int EXP_HIGH_DIV9   = 9;

endpackage

// File: rtl/dual_edge_sampler.sv
// Samples clk_in on both sys_clk edges and presents one ordered sample pair per cycle
// (A = negedge sample, B = posedge sample) together with edge positions inside the pair.
module dual_edge_sampler
    import div_meter_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       clk_in,
    output logic [1:0] pair,
    output logic       prev_b,
    output logic [1:0] rise_pos,
    output logic [1:0] fall_pos
);

    logic       s_n;
    logic       s_p;
    logic       a_smp;
    logic [1:0] primed;

    always_ff @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) s_n <= 1'b0;
        else            s_n <= clk_in;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_smp  <= 1'b0;
            s_p    <= 1'b0;
            prev_b <= 1'b0;
            primed <= '0;
        end else begin
            a_smp  <= s_n;
            s_p    <= clk_in;
            prev_b <= s_p;
            primed <= {primed[0], 1'b1};
        end
    end

    assign pair = {a_smp, s_p};

    // Edges are suppressed until all three samples postdate reset, so reset-zeroed
    // registers cannot fake a rise while clk_in is already high.
    assign rise_pos = primed[1] ? {~a_smp & s_p, ~prev_b & a_smp} : 2'b00;
    assign fall_pos = primed[1] ? {a_smp & ~s_p, prev_b & ~a_smp} : 2'b00;

endmodule

// File: rtl/div_clk_meter.sv
// Period / high-time checker for odd-ratio 50%-duty dividers, half-cycle resolution.
// Optional `DIV_CLK_METER_MINMAX_EN adds per_min / per_max tracking outputs.
module div_clk_meter
    import div_meter_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = EXP_PERIOD_DIV7,
    parameter int EXP_HIGH   = EXP_HIGH_DIV7,
    parameter int TOL        = 0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_hc,
    output logic [CNT_W-1:0] high_hc,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             meas_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             stuck,
    output logic             ovf
`ifdef DIV_CLK_METER_MINMAX_EN
    ,
    output logic [CNT_W-1:0] per_min,
    output logic [CNT_W-1:0] per_max
`endif
);

    localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
    localparam logic [1:0]              HC_INC    = HC_PER_CYC[1:0];
    localparam logic signed [CNT_W:0]   EXP_PER_S = EXP_PERIOD[CNT_W:0];
    localparam logic signed [CNT_W:0]   EXP_HI_S  = EXP_HIGH[CNT_W:0];
    localparam logic signed [CNT_W:0]   TOL_S     = TOL[CNT_W:0];

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, x} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
    endfunction

    logic [1:0] pair;
    logic       prev_b;
    logic [1:0] rise_pos;
    logic [1:0] fall_pos;
    logic [2:0] unused_edge_info;

    dual_edge_sampler u_sampler (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .clk_in   (clk_in),
        .pair     (pair),
        .prev_b   (prev_b),
        .rise_pos (rise_pos),
        .fall_pos (fall_pos)
    );

    assign unused_edge_info = {prev_b, fall_pos};

    meter_state_t     state, state_nxt;
    logic [CNT_W-1:0] per_cnt, hi_cnt, per_nxt, hi_nxt;
    logic [CNT_W-1:0] adv_per, adv_hi, close_per, close_hi, restart_per, restart_hi;
    logic [1:0]       ones;
    logic             rise, stuck_hit, complete, stuck_set, new_err;
    logic signed [CNT_W:0] d_per, d_hi;

    assign rise = |rise_pos;
    assign ones = {1'b0, pair[1]} + {1'b0, pair[0]};
    assign adv_per = sat_add(per_cnt, HC_INC);
    assign adv_hi  = sat_add(hi_cnt, ones);

    // A rise on B closes the old period one sample later than a rise on A.
    assign close_per   = rise_pos[1] ? sat_add(per_cnt, 2'd1) : per_cnt;
    assign close_hi    = rise_pos[1] ? sat_add(hi_cnt, {1'b0, pair[1]}) : hi_cnt;
    assign restart_per = rise_pos[0] ? CNT_W'(HC_PER_CYC) : CNT_W'(1);
    assign restart_hi  = rise_pos[0] ? (CNT_W'(1) + CNT_W'(pair[0])) : CNT_W'(1);

    assign stuck_hit = !rise && (adv_per == CNT_MAX) && (state != IDLE);

    assign d_per   = $signed({1'b0, close_per}) - EXP_PER_S;
    assign d_hi    = $signed({1'b0, close_hi}) - EXP_HI_S;
    assign new_err = (d_per > TOL_S) || (d_per < -TOL_S) || (d_hi > TOL_S) || (d_hi < -TOL_S);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ALIGN;
                ALIGN:   if (rise) state_nxt = MEAS;
                MEAS:    if (stuck_hit) state_nxt = ALIGN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        per_nxt   = '0;
        hi_nxt    = '0;
        complete  = 1'b0;
        stuck_set = 1'b0;
        if (en && (state == ALIGN || state == MEAS)) begin
            if (rise) begin
                per_nxt  = restart_per;
                hi_nxt   = restart_hi;
                complete = (state == MEAS);
            end else if (stuck_hit) begin
                stuck_set = 1'b1;
            end else begin
                per_nxt = adv_per;
                hi_nxt  = adv_hi;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else begin
            per_cnt <= per_nxt;
            hi_cnt  <= hi_nxt;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            period_hc  <= '0;
            high_hc    <= '0;
            meas_valid <= 1'b0;
            meas_err   <= 1'b0;
            err_cnt    <= '0;
            stuck      <= 1'b0;
            ovf        <= 1'b0;
`ifdef DIV_CLK_METER_MINMAX_EN
            per_min    <= '1;
            per_max    <= '0;
`endif
        end else begin
            if (stuck_set) stuck <= 1'b1;
            if (complete) begin
                if (!meas_valid || meas_ready) begin
                    period_hc  <= close_per;
                    high_hc    <= close_hi;
                    meas_err   <= new_err;
                    meas_valid <= 1'b1;
                    if (new_err && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
`ifdef DIV_CLK_METER_MINMAX_EN
                    if (close_per < per_min) per_min <= close_per;
                    if (close_per > per_max) per_max <= close_per;
`endif
                end else begin
                    ovf <= 1'b1;
                end
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_div_clk_meter.sv
// Directed bench for div_clk_meter: /7, /6, duty-skewed /7, stuck, overrun and reset cases.
module tb_div_clk_meter;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic       en         = 1'b0;
    logic       clk_in     = 1'b0;
    logic       meas_ready = 1'b1;

    logic [7:0] period_hc, high_hc, err_cnt;
    logic       meas_valid, meas_err, stuck, ovf;
    logic [7:0] t_period, t_high, t_err_cnt;
    logic       t_valid, t_err, t_stuck, t_ovf;

    int n_total = 0;
    int n_pass  = 0;

    int unsigned gen_high = 7;
    int unsigned gen_low  = 7;
    int unsigned gen_pos  = 0;
    bit          gen_hold = 1'b1;

    div_clk_meter #(.CNT_W(8), .EXP_PERIOD(14), .EXP_HIGH(7), .TOL(0)) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .clk_in    (clk_in),
        .period_hc (period_hc),
        .high_hc   (high_hc),
        .meas_valid(meas_valid),
        .meas_ready(meas_ready),
        .meas_err  (meas_err),
        .err_cnt   (err_cnt),
        .stuck     (stuck),
        .ovf       (ovf)
    );

    div_clk_meter #(.CNT_W(8), .EXP_PERIOD(14), .EXP_HIGH(7), .TOL(1)) u_tol (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .clk_in    (clk_in),
        .period_hc (t_period),
        .high_hc   (t_high),
        .meas_valid(t_valid),
        .meas_ready(meas_ready),
        .meas_err  (t_err),
        .err_cnt   (t_err_cnt),
        .stuck     (t_stuck),
        .ovf       (t_ovf)
    );

    always #5 sys_clk = ~sys_clk;

    // One clk_in sample per half-cycle, settled 1 ns after each sys_clk edge.
    initial forever begin
        @(sys_clk);
        #1;
        if (gen_hold) begin
            clk_in = 1'b0;
        end else begin
            clk_in  = (gen_pos < gen_high);
            gen_pos = (gen_pos + 1 >= gen_high + gen_low) ? 0 : gen_pos + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic set_pattern(input int unsigned hi, input int unsigned lo);
        gen_high = hi;
        gen_low  = lo;
        gen_pos  = 0;
        gen_hold = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i;
        i = 0;
        @(negedge sys_clk);
        while (meas_valid !== 1'b1 && i < budget) begin
            @(negedge sys_clk);
            i++;
        end
        check(tag, 32'(meas_valid), 1);
    endtask

    initial begin
        int cnt;
        int e0;
        bit saw;

        // reset state
        repeat (3) @(negedge sys_clk);
        check("rst_period", 32'(period_hc), 0);
        check("rst_high",   32'(high_hc), 0);
        check("rst_valid",  32'(meas_valid), 0);
        check("rst_err",    32'(meas_err), 0);
        check("rst_errcnt", 32'(err_cnt), 0);
        check("rst_stuck",  32'(stuck), 0);
        check("rst_ovf",    32'(ovf), 0);

        // /7 at 50% duty
        #2;
        sys_rst_n = 1'b1;
        en        = 1'b1;
        set_pattern(7, 7);
        wait_valid("t1_first", 40);
        check("t1_period", 32'(period_hc), 14);
        check("t1_high",   32'(high_hc), 7);
        check("t1_err",    32'(meas_err), 0);
        cnt = 0;
        repeat (70) begin
            @(negedge sys_clk);
            if (meas_valid === 1'b1) cnt++;
        end
        check("t1_valid_rate", 32'(cnt), 10);
        check("t1_errcnt", 32'(err_cnt), 0);
        check("t1_ovf",    32'(ovf), 0);

        // consumer stalls; later results (14,8) must be dropped
        meas_ready = 1'b0;
        wait_valid("t4_first", 20);
        check("t4_period", 32'(period_hc), 14);
        check("t4_high",   32'(high_hc), 7);
        set_pattern(8, 6);
        repeat (20) @(negedge sys_clk);
        check("t4_held_valid",  32'(meas_valid), 1);
        check("t4_held_period", 32'(period_hc), 14);
        check("t4_held_high",   32'(high_hc), 7);
        check("t4_ovf",         32'(ovf), 1);
        meas_ready = 1'b1;

        // /7 with 8:6 half-cycle duty: error at TOL=0, clean at TOL=1
        repeat (30) @(negedge sys_clk);
        wait_valid("t6_valid", 20);
        check("t6_period",   32'(period_hc), 14);
        check("t6_high",     32'(high_hc), 8);
        check("t6_err_tol0", 32'(meas_err), 1);
        check("t6_high_tol1", 32'(t_high), 8);
        check("t6_err_tol1", 32'(t_err), 0);

        // /6 at 50% duty
        set_pattern(6, 6);
        repeat (30) @(negedge sys_clk);
        wait_valid("t2_valid", 20);
        check("t2_period", 32'(period_hc), 12);
        check("t2_high",   32'(high_hc), 6);
        check("t2_err",    32'(meas_err), 1);
        e0 = int'(err_cnt);
        wait_valid("t2_next", 20);
        check("t2_errcnt_inc", 32'(err_cnt), 32'(e0 + 1));
        repeat (1700) @(negedge sys_clk);
        check("t2_errcnt_sat", 32'(err_cnt), 255);

        // clk_in held low
        gen_hold = 1'b1;
        repeat (100) @(negedge sys_clk);
        check("t3_stuck_early", 32'(stuck), 0);
        check("t3_valid_early", 32'(meas_valid), 0);
        repeat (60) @(negedge sys_clk);
        check("t3_stuck", 32'(stuck), 1);
        check("t3_valid", 32'(meas_valid), 0);
        set_pattern(7, 7);
        wait_valid("t3_realign", 40);
        check("t3_period", 32'(period_hc), 14);
        check("t3_high",   32'(high_hc), 7);

        // reset mid-period with a pending result
        meas_ready = 1'b0;
        wait_valid("t5_pending", 20);
        repeat (3) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check("t5_period", 32'(period_hc), 0);
        check("t5_high",   32'(high_hc), 0);
        check("t5_valid",  32'(meas_valid), 0);
        check("t5_err",    32'(meas_err), 0);
        check("t5_errcnt", 32'(err_cnt), 0);
        check("t5_stuck",  32'(stuck), 0);
        check("t5_ovf",    32'(ovf), 0);
        @(negedge sys_clk);
        #2;
        sys_rst_n  = 1'b1;
        meas_ready = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge sys_clk);
            if (meas_valid === 1'b1) saw = 1'b1;
        end
        check("t5_no_early_valid", 32'(saw), 0);
        wait_valid("t5_first", 30);
        check("t5_first_period", 32'(period_hc), 14);
        check("t5_first_high",   32'(high_hc), 7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
